xfer_seq: RTL
=============

// Module: xfer_seq
// PURPOSE
//  DMA transfer sequencer for the REU. Consumes command/length state from the register block, takes the C64 bus via nDMA,
//  steps byte transfers (C64->REU, REU->C64, swap, verify), and pulses NextCA/NextREUA/XferEnd/VerifyErr back into the
//  register block. Sits between the register block, the C64 bus interface and the REU DRAM controller.
// PARAMETERS
//  DMA_SETTLE  1  PHI2 cycles between nDMA assertion and the first bus access (1..3)
// PORTS
//  PHI2       in   1  system clock; all state updates on negedge PHI2
//  Reset      in   1  synchronous, active-high reset
//  Execute    in   1  command register execute bit
//  FF00Decode in   1  1 = arm, then start only on a CPU write to $FF00
//  XferType   in   2  00 C64->REU, 01 REU->C64, 10 swap, 11 verify
//  Length1    in   1  current length register == 1 (last byte)
//  FixCA      in   1  hold C64 address (no NextCA)
//  FixREUA    in   1  hold REU address (no NextREUA)
//  WrFF00     in   1  decoded CPU write cycle to $FF00
//  BA         in   1  VIC bus available; 0 = stall before any C64 access
//  C64Din     in   8  C64 data bus (valid in C64 read state)
//  REUDin     in   8  REU DRAM read data (valid in REU read state)
//  nDMA       out  1  C64 DMA request, active low
//  C64RD      out  1  C64 read strobe this cycle
//  C64WR      out  1  C64 write strobe this cycle
//  REURD      out  1  REU DRAM read strobe
//  REUWR      out  1  REU DRAM write strobe
//  C64Dout    out  8  data driven for C64 write
//  REUDout    out  8  data driven for REU write
//  NextCA     out  1  one-cycle pulse: increment C64 address and decrement length
//  NextREUA   out  1  one-cycle pulse: increment REU address
//  XferEnd    out  1  one-cycle pulse: last byte done
//  VerifyErr  out  1  one-cycle pulse: verify mismatch
//  Busy       out  1  high in any state other than IDLE/ARM
// BEHAVIOUR
//  Reset: state IDLE; nDMA=1; all strobes/pulses 0; C64Dout=REUDout=0; data latches 0. Reset mid-transfer aborts at the same edge.
//  States: IDLE, ARM, SETTLE, C_RD, R_RD, C_WR, R_WR, RELEASE.
//  IDLE: Execute&!FF00Decode -> SETTLE; Execute&FF00Decode -> ARM. ARM: WrFF00 -> SETTLE; !Execute -> IDLE.
//  SETTLE: nDMA=0; counts DMA_SETTLE cycles, then goes to the first access state for XferType.
//  Byte sequences: 00 C_RD->R_WR; 01 R_RD->C_WR; 10 C_RD->R_RD->C_WR->R_WR; 11 C_RD->R_RD.
//  Each access state: one cycle, one strobe. C_RD latches C64Din to dc; R_RD latches REUDin to dr. C_WR drives dr; R_WR drives dc.
//  C_RD/C_WR with BA=0: hold state, strobe 0, no pulses. nDMA stays 0.
//  Final state of a byte: if Length1 -> XferEnd=1, NextCA=NextREUA=0, then RELEASE; else NextCA=!FixCA, NextREUA=!FixREUA, loop.
//  Verify: mismatch (C64Din latch vs REUDin in R_RD) -> VerifyErr=1, no XferEnd/Next*, RELEASE. Match on last byte -> XferEnd only.
//  Length decrement is owned by the register block via NextCA, so a FixCA transfer never decrements; it terminates only by verify
//  error or reset (fixed-C64 DMA unsupported).
//  RELEASE: nDMA=1 for one cycle, then IDLE. Execute is cleared by the register block on XferEnd/VerifyErr.
//  XferEnd and VerifyErr are never both high. Per byte: 2 cycles (types 00/01/11), 4 cycles (swap); first access at
//  DMA_SETTLE+1 cycles after start.
// STRUCTURE
//  Shared package reu_pkg: XFER_C2R/R2C/SWAP/VERIFY = 2'b00..11, state encoding enum xfer_state_t.
//  Single module; no sub-module. dc/dr 8-bit latches, settle counter 2 bits.
// TESTING
//  Type 00, len=3, dc bytes 11,22,33, BA=1 -> 3 R_WR writes of 11,22,33; NextCA/NextREUA x2; XferEnd once; 7 cycles nDMA=0.
//  Type 10, len=1, C64=AA, REU=55 -> C_WR drives 55, R_WR drives AA; XferEnd on R_WR cycle; no Next*.
//  Type 11, len=4, mismatch at byte 2 -> VerifyErr on 2nd R_RD; exactly 1 NextCA; no XferEnd; nDMA released.
//  FF00Decode=1, Execute=1 -> stays ARM, nDMA=1, until WrFF00 pulse; SETTLE follows next cycle.
//  Type 01 with BA low 3 cycles at C_WR -> C_WR held 3 cycles, no strobes; write completes when BA=1.
//  Reset asserted in R_WR of type 00 -> next cycle IDLE, nDMA=1, no XferEnd/Next* pulses.

Source files
------------

// File: rtl/xfer_seq_pkg.sv
// Shared REU transfer-type codes and sequencer state encoding.
// Purely combinational helpers; no timing or backpressure of their own.
package xfer_seq_pkg;

   localparam logic [1:0] XFER_C2R    = 2'b00;
   localparam logic [1:0] XFER_R2C    = 2'b01;
   localparam logic [1:0] XFER_SWAP   = 2'b10;
   localparam logic [1:0] XFER_VERIFY = 2'b11;

   typedef enum logic [2:0] {
      IDLE, ARM, SETTLE, C_RD, R_RD, C_WR, R_WR, RELEASE
   } xfer_state_t;

   // Every byte of a REU->C64 transfer starts with the REU read; all others with the C64 read.
   function automatic xfer_state_t firstAccess(input logic [1:0] xferType);
      xfer_state_t s;
      if (xferType == XFER_R2C) s = R_RD;
      else                      s = C_RD;
      return s;
   endfunction

endpackage

// File: rtl/xfer_seq_if.sv
// Sequencer <-> register block / C64 bus / REU DRAM signal bundle.
// Strobes and pulses are single-cycle; BA low stalls C64-side accesses.
interface xfer_seq_if;

   logic       Execute;
   logic       FF00Decode;
   logic [1:0] XferType;
   logic       Length1;
   logic       FixCA;
   logic       FixREUA;
   logic       WrFF00;
   logic       BA;
   logic [7:0] C64Din;
   logic [7:0] REUDin;
   logic       nDMA;
   logic       C64RD;
   logic       C64WR;
   logic       REURD;
   logic       REUWR;
   logic [7:0] C64Dout;
   logic [7:0] REUDout;
   logic       NextCA;
   logic       NextREUA;
   logic       XferEnd;
   logic       VerifyErr;
   logic       Busy;

   modport master (
      input  Execute, FF00Decode, XferType, Length1, FixCA, FixREUA, WrFF00, BA, C64Din, REUDin,
      output nDMA, C64RD, C64WR, REURD, REUWR, C64Dout, REUDout, NextCA, NextREUA, XferEnd,
             VerifyErr, Busy
   );

   modport slave (
      output Execute, FF00Decode, XferType, Length1, FixCA, FixREUA, WrFF00, BA, C64Din, REUDin,
      input  nDMA, C64RD, C64WR, REURD, REUWR, C64Dout, REUDout, NextCA, NextREUA, XferEnd,
             VerifyErr, Busy
   );

endinterface

// File: rtl/xfer_seq.sv
// REU DMA transfer sequencer: first access DMA_SETTLE+1 cycles after Execute, then one access per cycle.
// BA low holds C_RD/C_WR with strobes and pulses suppressed; nDMA stays asserted while stalled.
module xfer_seq
   import xfer_seq_pkg::*;
#(
   parameter int DMA_SETTLE = 1
) (
   input logic        PHI2,
   input logic        Reset,
   xfer_seq_if.master bus
);

   localparam logic [1:0] SETTLE_LAST = 2'(DMA_SETTLE - 1);

   xfer_state_t state;
   logic [1:0]  settleCnt;
   logic [7:0]  dc;
   logic [7:0]  dr;
   logic        nDMAq;
   logic        isVerify;
   logic        mismatch;
   logic        byteDone;

   // Strobes and pulses qualify against same-cycle BA, Length1 and REUDin, so they are decoded from state.
   always_comb begin
      isVerify = (bus.XferType == XFER_VERIFY);
      mismatch = (dc != bus.REUDin);
      byteDone = !Reset && ((state == R_WR)
                         || (state == C_WR && bus.XferType == XFER_R2C && bus.BA)
                         || (state == R_RD && isVerify && !mismatch));
   end

   assign bus.C64RD     = !Reset && state == C_RD && bus.BA;
   assign bus.C64WR     = !Reset && state == C_WR && bus.BA;
   assign bus.REURD     = !Reset && state == R_RD;
   assign bus.REUWR     = !Reset && state == R_WR;
   assign bus.XferEnd   = byteDone && bus.Length1;
   assign bus.NextCA    = byteDone && !bus.Length1 && !bus.FixCA;
   assign bus.NextREUA  = byteDone && !bus.Length1 && !bus.FixREUA;
   assign bus.VerifyErr = !Reset && state == R_RD && isVerify && mismatch;
   assign bus.C64Dout   = dr;
   assign bus.REUDout   = dc;
   assign bus.nDMA      = nDMAq;
   assign bus.Busy      = (state != IDLE) && (state != ARM);

   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state     <= IDLE;
         nDMAq     <= 1'b1;
         settleCnt <= 2'd0;
         dc        <= 8'd0;
         dr        <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               settleCnt <= 2'd0;
               if (bus.Execute) begin
                  if (bus.FF00Decode) begin
                     state <= ARM;
                  end else begin
                     state <= SETTLE;
                     nDMAq <= 1'b0;
                  end
               end
            end
            ARM: begin
               settleCnt <= 2'd0;
               if (bus.WrFF00) begin
                  state <= SETTLE;
                  nDMAq <= 1'b0;
               end else if (!bus.Execute) begin
                  state <= IDLE;
               end
            end
            SETTLE: begin
               if (settleCnt == SETTLE_LAST) state <= firstAccess(bus.XferType);
               else                          settleCnt <= settleCnt + 2'd1;
            end
            C_RD: begin
               if (bus.BA) begin
                  dc    <= bus.C64Din;
                  state <= (bus.XferType == XFER_C2R) ? R_WR : R_RD;
               end
            end
            R_RD: begin
               dr <= bus.REUDin;
               if (isVerify) begin
                  // A verify byte ends the transfer on either a mismatch or the last byte.
                  nDMAq <= mismatch || bus.Length1;
                  state <= (mismatch || bus.Length1) ? RELEASE : C_RD;
               end else begin
                  state <= C_WR;
               end
            end
            C_WR: begin
               if (bus.BA) begin
                  if (bus.XferType == XFER_SWAP) begin
                     state <= R_WR;
                  end else begin
                     nDMAq <= bus.Length1;
                     state <= bus.Length1 ? RELEASE : firstAccess(bus.XferType);
                  end
               end
            end
            R_WR: begin
               nDMAq <= bus.Length1;
               state <= bus.Length1 ? RELEASE : firstAccess(bus.XferType);
            end
            RELEASE: state <= IDLE;
            default: begin
               state <= IDLE;
               nDMAq <= 1'b1;
            end
         endcase
      end
   end

endmodule
